// File: rtl/fb_port_arbiter_if.sv
// Bus bundle between the sprite-BRAM arbiter, its two requesters and the BRAM.
// The arbiter is the slave; requesters and the BRAM model sit on the master side.
interface fb_port_arbiter_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_W    = 8
);
    logic                 rd_req;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_valid;

    logic                 wr_valid;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic                 wr_ready;

    logic                 ram_en;
    logic                 ram_we;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [DATA_W-1:0]    ram_wdata;
    logic [DATA_W-1:0]    ram_rdata;

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
        output rd_data, rd_valid, wr_ready, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
        input  rd_data, rd_valid, wr_ready, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port sprite BRAM arbiter: display reads always win with fixed 2-cycle
// latency; upload writes are queued in a small FIFO and drained on idle slots.
module fb_port_arbiter #(
    parameter int ADDR_BITS  = 16,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int SAFE_WR    = 1,
    parameter int STARVE_LIM = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    fb_port_arbiter_if.slave            bus,
    input  logic                        blank,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        wr_starve
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int SW = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t               state;
    logic [ADDR_BITS-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]    fifo_data [FIFO_DEPTH];
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [LW-1:0]        level;
    logic [SW-1:0]        starve_cnt;
    logic [SW-1:0]        starve_next;
    logic                 fifo_nonempty;
    logic                 push;
    logic                 pop;

    assign bus.wr_ready = (level < LW'(FIFO_DEPTH));
    assign bus.rd_data  = bus.ram_rdata;
    assign fifo_level   = level;

    // Pop decision uses the registered level, so a write pushed into an empty
    // FIFO can drain at the earliest on the following edge.
    always_comb begin
        fifo_nonempty = (level != '0);
        push          = bus.wr_valid && bus.wr_ready;
        pop           = !bus.rd_req && fifo_nonempty && ((SAFE_WR == 0) || blank);
        starve_next   = starve_cnt;
        if (!fifo_nonempty || pop)
            starve_next = '0;
        else if (starve_cnt < SW'(STARVE_LIM))
            starve_next = starve_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[tail] <= bus.wr_addr;
            fifo_data[tail] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bus.ram_en    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.rd_valid  <= 1'b0;
            head          <= '0;
            tail          <= '0;
            level         <= '0;
            starve_cnt    <= '0;
            wr_starve     <= 1'b0;
        end else begin
            bus.rd_valid <= (state == RD);
            starve_cnt   <= starve_next;
            if (starve_next == SW'(STARVE_LIM))
                wr_starve <= 1'b1;

            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            level <= level + LW'(push) - LW'(pop);

            if (bus.rd_req) begin
                state        <= RD;
                bus.ram_en   <= 1'b1;
                bus.ram_we   <= 1'b0;
                bus.ram_addr <= bus.rd_addr;
            end else if (pop) begin
                state         <= WR;
                bus.ram_en    <= 1'b1;
                bus.ram_we    <= 1'b1;
                bus.ram_addr  <= fifo_addr[head];
                bus.ram_wdata <= fifo_data[head];
            end else begin
                state      <= IDLE;
                bus.ram_en <= 1'b0;
                bus.ram_we <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: one SAFE_WR=1 instance (short starve limit)
// and one SAFE_WR=0 instance, each attached to a small behavioural BRAM.
module tb_fb_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic blank_a = 1'b0;
    logic blank_b = 1'b0;
    logic [2:0] level_a, level_b;
    logic starve_a, starve_b;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fb_port_arbiter_if #(.ADDR_BITS(8), .DATA_W(8)) ifa ();
    fb_port_arbiter_if #(.ADDR_BITS(8), .DATA_W(8)) ifb ();

    fb_port_arbiter #(.ADDR_BITS(8), .DATA_W(8), .FIFO_DEPTH(4), .SAFE_WR(1), .STARVE_LIM(16)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave), .blank(blank_a),
        .fifo_level(level_a), .wr_starve(starve_a));

    fb_port_arbiter #(.ADDR_BITS(8), .DATA_W(8), .FIFO_DEPTH(4), .SAFE_WR(0)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave), .blank(blank_b),
        .fifo_level(level_b), .wr_starve(starve_b));

    // BRAM models: preloaded with mem[a] = a + 0x10 while reset is held
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    int wr_events_a = 0;

    always @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < 256; a++) mem_a[a] <= 8'(a + 16);
        end else if (ifa.ram_en) begin
            if (ifa.ram_we) begin
                mem_a[ifa.ram_addr] <= ifa.ram_wdata;
                wr_events_a <= wr_events_a + 1;
            end else begin
                ifa.ram_rdata <= mem_a[ifa.ram_addr];
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < 256; a++) mem_b[a] <= 8'(a + 16);
        end else if (ifb.ram_en) begin
            if (ifb.ram_we) mem_b[ifb.ram_addr] <= ifb.ram_wdata;
            else            ifb.ram_rdata <= mem_b[ifb.ram_addr];
        end
    end

    typedef struct {
        logic       rd_req;
        logic [7:0] rd_addr;
        logic       wr_valid;
        logic [7:0] wr_addr;
        logic [7:0] wr_data;
        logic       blank;
        logic       e_en;
        logic       e_we;
        logic [7:0] e_addr;
        logic [7:0] e_wdata;
        logic       e_valid;
        logic [7:0] e_rdata;
        logic [2:0] e_level;
        logic       e_ready;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rd, logic [7:0] ra, logic wv, logic [7:0] wa, logic [7:0] wd,
                                logic bl, logic en, logic we, logic [7:0] ea, logic [7:0] ew,
                                logic vl, logic [7:0] er, logic [2:0] lv, logic rdy);
        vec_t v;
        v.rd_req = rd; v.rd_addr = ra; v.wr_valid = wv; v.wr_addr = wa; v.wr_data = wd;
        v.blank = bl; v.e_en = en; v.e_we = we; v.e_addr = ea; v.e_wdata = ew;
        v.e_valid = vl; v.e_rdata = er; v.e_level = lv; v.e_ready = rdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic rd, input logic [7:0] ra, input logic wv,
                           input logic [7:0] wa, input logic [7:0] wd, input logic bl);
        @(negedge clk);
        ifa.rd_req = rd; ifa.rd_addr = ra; ifa.wr_valid = wv;
        ifa.wr_addr = wa; ifa.wr_data = wd; blank_a = bl;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic rd, input logic [7:0] ra, input logic wv,
                           input logic [7:0] wa, input logic [7:0] wd);
        @(negedge clk);
        ifb.rd_req = rd; ifb.rd_addr = ra; ifb.wr_valid = wv;
        ifb.wr_addr = wa; ifb.wr_data = wd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        ifa.rd_req = 0; ifa.rd_addr = 0; ifa.wr_valid = 0; ifa.wr_addr = 0; ifa.wr_data = 0;
        ifb.rd_req = 0; ifb.rd_addr = 0; ifb.wr_valid = 0; ifb.wr_addr = 0; ifb.wr_data = 0;

        // Back-to-back reads of 0..7, then a 5-deep write burst against a 4-entry FIFO
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(i < 8, 8'(i), 0, 0, 0, 0, i < 8, 0, 8'(i), 0,
                             (i >= 1) && (i <= 8), 8'(16 + i - 1), 0, 1));
        tbl.push_back(mk(0, 0, 1, 8'h40, 8'hA0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 8'h41, 8'hA1, 0, 0, 0, 0, 0, 0, 0, 2, 1));
        tbl.push_back(mk(0, 0, 1, 8'h42, 8'hA2, 0, 0, 0, 0, 0, 0, 0, 3, 1));
        tbl.push_back(mk(0, 0, 1, 8'h43, 8'hA3, 0, 0, 0, 0, 0, 0, 0, 4, 0));
        tbl.push_back(mk(0, 0, 1, 8'h44, 8'hA4, 0, 0, 0, 0, 0, 0, 0, 4, 0));
        tbl.push_back(mk(0, 0, 1, 8'h44, 8'hA4, 1, 1, 1, 8'h40, 8'hA0, 0, 0, 3, 1));
        tbl.push_back(mk(0, 0, 1, 8'h44, 8'hA4, 1, 1, 1, 8'h41, 8'hA1, 0, 0, 3, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 8'h42, 8'hA2, 0, 0, 2, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 8'h43, 8'hA3, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 8'h44, 8'hA4, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        repeat (10) drive_a(0, 0, 0, 0, 0, 0);
        chk("idle_ram_en", ifa.ram_en, 0);
        chk("idle_ram_we", ifa.ram_we, 0);
        chk("idle_rd_valid", ifa.rd_valid, 0);
        chk("idle_wr_ready", ifa.wr_ready, 1);
        chk("idle_level", level_a, 0);
        chk("idle_starve", starve_a, 0);

        foreach (tbl[i]) begin
            drive_a(tbl[i].rd_req, tbl[i].rd_addr, tbl[i].wr_valid, tbl[i].wr_addr,
                    tbl[i].wr_data, tbl[i].blank);
            chk($sformatf("v%0d_ram_en", i), ifa.ram_en, tbl[i].e_en);
            chk($sformatf("v%0d_ram_we", i), ifa.ram_we, tbl[i].e_we);
            if (tbl[i].e_en) chk($sformatf("v%0d_ram_addr", i), ifa.ram_addr, tbl[i].e_addr);
            if (tbl[i].e_we) chk($sformatf("v%0d_ram_wdata", i), ifa.ram_wdata, tbl[i].e_wdata);
            chk($sformatf("v%0d_rd_valid", i), ifa.rd_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) chk($sformatf("v%0d_rd_data", i), ifa.rd_data, tbl[i].e_rdata);
            chk($sformatf("v%0d_level", i), level_a, tbl[i].e_level);
            chk($sformatf("v%0d_wr_ready", i), ifa.wr_ready, tbl[i].e_ready);
        end

        // Starvation: one write held off by blank=0, flag sets when the count hits 16
        drive_a(0, 0, 1, 8'h50, 8'h5A, 0);
        chk("starve_push_level", level_a, 1);
        for (int k = 1; k <= 20; k++) begin
            drive_a(0, 0, 0, 0, 0, 0);
            chk($sformatf("starve_k%0d", k), starve_a, (k >= 16) ? 1 : 0);
        end
        chk("starve_no_we", ifa.ram_we, 0);
        drive_a(0, 0, 0, 0, 0, 1);
        chk("starve_drain_we", ifa.ram_we, 1);
        chk("starve_drain_addr", ifa.ram_addr, 8'h50);
        chk("starve_drain_wdata", ifa.ram_wdata, 8'h5A);
        chk("starve_drain_level", level_a, 0);
        chk("starve_sticky", starve_a, 1);
        drive_a(0, 0, 0, 0, 0, 1);
        chk("starve_sticky2", starve_a, 1);

        // SAFE_WR=0: writes take only the slots where rd_req was low
        drive_b(1, 8'h01, 1, 8'h20, 8'hC1);
        chk("b0_rd", {ifb.ram_en, ifb.ram_we, ifb.ram_addr}, {2'b10, 8'h01});
        chk("b0_level", level_b, 1);
        drive_b(0, 0, 1, 8'h21, 8'hC2);
        chk("b1_wr", {ifb.ram_en, ifb.ram_we, ifb.ram_addr, ifb.ram_wdata}, {2'b11, 8'h20, 8'hC1});
        chk("b1_level", level_b, 1);
        chk("b1_rd_valid", {ifb.rd_valid, ifb.rd_data}, {1'b1, 8'h11});
        drive_b(1, 8'h20, 0, 0, 0);
        chk("b2_rd", {ifb.ram_en, ifb.ram_we, ifb.ram_addr}, {2'b10, 8'h20});
        chk("b2_rd_valid", ifb.rd_valid, 0);
        drive_b(0, 0, 0, 0, 0);
        chk("b3_wr", {ifb.ram_en, ifb.ram_we, ifb.ram_addr, ifb.ram_wdata}, {2'b11, 8'h21, 8'hC2});
        chk("b3_level", level_b, 0);
        chk("b3_readback", {ifb.rd_valid, ifb.rd_data}, {1'b1, 8'hC1});
        drive_b(1, 8'h21, 0, 0, 0);
        chk("b4_rd", {ifb.ram_en, ifb.ram_we, ifb.ram_addr}, {2'b10, 8'h21});
        chk("b4_rd_valid", ifb.rd_valid, 0);
        drive_b(0, 0, 0, 0, 0);
        chk("b5_idle", {ifb.ram_en, ifb.ram_we}, 2'b00);
        chk("b5_readback", {ifb.rd_valid, ifb.rd_data}, {1'b1, 8'hC2});

        // Reset with 3 queued writes and a read in flight
        for (int i = 0; i < 3; i++) drive_a(0, 0, 1, 8'(8'h60 + i), 8'(8'hE0 + i), 0);
        chk("rst_pre_level", level_a, 3);
        drive_a(1, 8'h05, 0, 0, 0, 0);
        chk("rst_pre_rd", {ifa.ram_en, ifa.ram_we}, 2'b10);
        n0 = wr_events_a;
        @(negedge clk);
        reset = 1; ifa.rd_req = 0;
        @(posedge clk);
        #1;
        chk("rst_level", level_a, 0);
        chk("rst_rd_valid", ifa.rd_valid, 0);
        chk("rst_ram_we", ifa.ram_we, 0);
        chk("rst_ram_en", ifa.ram_en, 0);
        chk("rst_starve", starve_a, 0);
        @(negedge clk);
        reset = 0;
        repeat (8) drive_a(0, 0, 0, 0, 0, 1);
        chk("rst_no_writes", wr_events_a - n0, 0);
        chk("rst_post_level", level_a, 0);
        chk("rst_post_rd_valid", ifa.rd_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
